// File: rtl/regread_pkg.sv
// Shared types and default sizes for the register-read stage and its scoreboard.
package regread_pkg;

    localparam int XLEN_DEFAULT     = 32;
    localparam int NUM_REGS_DEFAULT = 32;
    localparam int REG_IDX_W        = $clog2(NUM_REGS_DEFAULT);

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        HOLD  = 2'd2
    } rr_state_t;

endpackage

// File: rtl/register_read_if.sv
// Decode, execute-handshake, writeback and operand signals of the register-read stage.
interface register_read_if #(
    parameter int XLEN      = 32,
    parameter int REG_IDX_W = 5
);
    logic                 decode_valid;
    logic [REG_IDX_W-1:0] decode_rs1;
    logic [REG_IDX_W-1:0] decode_rs2;
    logic [REG_IDX_W-1:0] decode_rd;
    logic                 decode_uses_rs1;
    logic                 decode_uses_rs2;
    logic                 decode_writes_rd;
    logic                 execute_processing;
    logic                 wb_valid;
    logic [REG_IDX_W-1:0] wb_rd;
    logic [XLEN-1:0]      wb_val;
    logic [XLEN-1:0]      read_rs1_val;
    logic [XLEN-1:0]      read_rs2_val;
    logic                 read_valid;
    logic                 processing;

    modport master (
        output decode_valid, decode_rs1, decode_rs2, decode_rd,
               decode_uses_rs1, decode_uses_rs2, decode_writes_rd,
               execute_processing, wb_valid, wb_rd, wb_val,
        input  read_rs1_val, read_rs2_val, read_valid, processing
    );

    modport slave (
        input  decode_valid, decode_rs1, decode_rs2, decode_rd,
               decode_uses_rs1, decode_uses_rs2, decode_writes_rd,
               execute_processing, wb_valid, wb_rd, wb_val,
        output read_rs1_val, read_rs2_val, read_valid, processing
    );
endinterface

// File: rtl/register_read_scoreboard.sv
// Pending-write bitmap: one bit per architectural register, x0 never pending.
module reg_scoreboard
    import regread_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEFAULT
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     set_en,
    input  reg_idx_t set_idx,
    input  logic     clr_en,
    input  reg_idx_t clr_idx,
    input  reg_idx_t look_a_idx,
    input  reg_idx_t look_b_idx,
    output logic     pend_a,
    output logic     pend_b
);
    logic [NUM_REGS-1:0] pending;

    // Set is applied after clear so a same-cycle set/clear of one index leaves it pending.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            if (clr_en && clr_idx != '0) pending[clr_idx] <= 1'b0;
            if (set_en && set_idx != '0) pending[set_idx] <= 1'b1;
        end
    end

    assign pend_a = pending[look_a_idx];
    assign pend_b = pending[look_b_idx];
endmodule

// File: rtl/register_read.sv
// Register-read stage: register file, hazard stall and operand hand-off to execute.
// Optional REGREAD_BYPASS_EN forwards a same-cycle writeback into a stalled operand.
//
// state | meaning
// IDLE  | waiting for a decoded instruction
// CHECK | instruction latched, stalling while a source is pending
// HOLD  | operands presented until execute accepts them
module register_read
    import regread_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int NUM_REGS = NUM_REGS_DEFAULT
) (
    input logic            clk,
    input logic            rst_n,
    register_read_if.slave bus
);
    rr_state_t       state;
    reg_idx_t        rs1_q, rs2_q, rd_q;
    logic            uses_rs1_q, uses_rs2_q, writes_rd_q;
    logic [XLEN-1:0] regs [NUM_REGS];
    logic [XLEN-1:0] rs1_val_q, rs2_val_q;
    logic            read_valid_q, processing_q;

    logic            pend_rs1, pend_rs2;
    logic            wb_write, dispatch;
    logic            hit_rs1, hit_rs2, hazard;
    logic [XLEN-1:0] src1, src2;

    assign wb_write = bus.wb_valid && bus.wb_rd != '0;
    assign dispatch = state == HOLD && !bus.execute_processing;

    always_comb begin
        hit_rs1 = 1'b0;
        hit_rs2 = 1'b0;
`ifdef REGREAD_BYPASS_EN
        hit_rs1 = wb_write && bus.wb_rd == rs1_q;
        hit_rs2 = wb_write && bus.wb_rd == rs2_q;
`endif
        hazard = (uses_rs1_q && pend_rs1 && !hit_rs1) ||
                 (uses_rs2_q && pend_rs2 && !hit_rs2);
        src1 = '0;
        src2 = '0;
        if (uses_rs1_q && rs1_q != '0) src1 = hit_rs1 ? bus.wb_val : regs[rs1_q];
        if (uses_rs2_q && rs2_q != '0) src2 = hit_rs2 ? bus.wb_val : regs[rs2_q];
    end

    reg_scoreboard #(.NUM_REGS(NUM_REGS)) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_en     (dispatch && writes_rd_q),
        .set_idx    (rd_q),
        .clr_en     (wb_write),
        .clr_idx    (bus.wb_rd),
        .look_a_idx (rs1_q),
        .look_b_idx (rs2_q),
        .pend_a     (pend_rs1),
        .pend_b     (pend_rs2)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wb_write) begin
            regs[bus.wb_rd] <= bus.wb_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            uses_rs1_q   <= 1'b0;
            uses_rs2_q   <= 1'b0;
            writes_rd_q  <= 1'b0;
            rs1_val_q    <= '0;
            rs2_val_q    <= '0;
            read_valid_q <= 1'b0;
            processing_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.decode_valid) begin
                        rs1_q        <= bus.decode_rs1;
                        rs2_q        <= bus.decode_rs2;
                        rd_q         <= bus.decode_rd;
                        uses_rs1_q   <= bus.decode_uses_rs1;
                        uses_rs2_q   <= bus.decode_uses_rs2;
                        writes_rd_q  <= bus.decode_writes_rd;
                        processing_q <= 1'b1;
                        state        <= CHECK;
                    end
                end
                CHECK: begin
                    if (!hazard) begin
                        rs1_val_q    <= src1;
                        rs2_val_q    <= src2;
                        read_valid_q <= 1'b1;
                        state        <= HOLD;
                    end
                end
                HOLD: begin
                    if (!bus.execute_processing) begin
                        read_valid_q <= 1'b0;
                        processing_q <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.read_rs1_val = rs1_val_q;
    assign bus.read_rs2_val = rs2_val_q;
    assign bus.read_valid   = read_valid_q;
    assign bus.processing   = processing_q;
endmodule

// File: tb/tb_register_read.sv
// Bench for register_read: directed scenarios with literal expectations, then random
// traffic checked every cycle against an instruction-level model of the stage.
module tb_register_read;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    register_read_if #(.XLEN(32), .REG_IDX_W(5)) bus ();

    register_read dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural registers, pending set, and the one instruction in flight.
    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          m_busy, m_pres;
    int          m_rs1, m_rs2, m_rd;
    bit          m_u1, m_u2, m_w;
    logic [31:0] m_op1, m_op2;
    bit          m_wb, m_disp, m_byp1, m_byp2, m_stall;

    function automatic logic [31:0] operand(bit used, int idx, bit byp, logic [31:0] wbv,
                                            logic [31:0] arch);
        if (!used || idx == 0) return 32'h0;
        return byp ? wbv : arch;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'h0;
                m_pend[i] = 1'b0;
            end
            m_busy = 0;
            m_pres = 0;
            m_op1  = 32'h0;
            m_op2  = 32'h0;
        end else begin
            m_wb   = bus.wb_valid && bus.wb_rd != 0;
            m_disp = 0;
            if (!m_busy) begin
                if (bus.decode_valid) begin
                    m_rs1  = int'(bus.decode_rs1);
                    m_rs2  = int'(bus.decode_rs2);
                    m_rd   = int'(bus.decode_rd);
                    m_u1   = bus.decode_uses_rs1;
                    m_u2   = bus.decode_uses_rs2;
                    m_w    = bus.decode_writes_rd;
                    m_busy = 1;
                end
            end else if (!m_pres) begin
                m_byp1 = 0;
                m_byp2 = 0;
`ifdef REGREAD_BYPASS_EN
                m_byp1 = m_wb && int'(bus.wb_rd) == m_rs1;
                m_byp2 = m_wb && int'(bus.wb_rd) == m_rs2;
`endif
                m_stall = (m_u1 && m_pend[m_rs1] && !m_byp1) ||
                          (m_u2 && m_pend[m_rs2] && !m_byp2);
                if (!m_stall) begin
                    m_op1  = operand(m_u1, m_rs1, m_byp1, bus.wb_val, m_regs[m_rs1]);
                    m_op2  = operand(m_u2, m_rs2, m_byp2, bus.wb_val, m_regs[m_rs2]);
                    m_pres = 1;
                end
            end else if (!bus.execute_processing) begin
                m_busy = 0;
                m_pres = 0;
                m_disp = m_w && m_rd != 0;
            end
            if (m_wb) begin
                m_regs[bus.wb_rd] = bus.wb_val;
                m_pend[bus.wb_rd] = 0;
            end
            if (m_disp) m_pend[m_rd] = 1;
        end
    end

    always @(negedge clk) begin
        n_checks++;
        if (bus.read_valid !== m_pres) begin
            n_fail++;
            $display("FAIL model_read_valid t=%0t got %b want %b", $time, bus.read_valid, m_pres);
        end
        n_checks++;
        if (bus.processing !== m_busy) begin
            n_fail++;
            $display("FAIL model_processing t=%0t got %b want %b", $time, bus.processing, m_busy);
        end
        if (m_pres) begin
            n_checks++;
            if (bus.read_rs1_val !== m_op1) begin
                n_fail++;
                $display("FAIL model_rs1_val t=%0t got %h want %h", $time, bus.read_rs1_val, m_op1);
            end
            n_checks++;
            if (bus.read_rs2_val !== m_op2) begin
                n_fail++;
                $display("FAIL model_rs2_val t=%0t got %h want %h", $time, bus.read_rs2_val, m_op2);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.decode_valid       = 0;
        bus.wb_valid           = 0;
        bus.execute_processing = 0;
    endtask

    task automatic decode(input int rs1, input int rs2, input int rd,
                          input bit u1, input bit u2, input bit w);
        bus.decode_valid     = 1;
        bus.decode_rs1       = 5'(rs1);
        bus.decode_rs2       = 5'(rs2);
        bus.decode_rd        = 5'(rd);
        bus.decode_uses_rs1  = u1;
        bus.decode_uses_rs2  = u2;
        bus.decode_writes_rd = w;
    endtask

    task automatic wb(input int rd, input logic [31:0] val);
        bus.wb_valid = 1;
        bus.wb_rd    = 5'(rd);
        bus.wb_val   = val;
    endtask

    // Issue an instruction that is expected to pass straight through and be accepted at once.
    task automatic run_clean(input int rs1, input int rs2, input int rd, input bit w);
        decode(rs1, rs2, rd, 1, 1, w);
        tick();
        bus.decode_valid = 0;
        tick();
        tick();
    endtask

    initial begin
        quiet();
        decode(0, 0, 0, 0, 0, 0);
        bus.decode_valid = 0;
        wb(0, 32'h0);
        bus.wb_valid = 0;
        tick();
        tick();
        chk("reset_read_valid", 32'(bus.read_valid), 32'h0);
        chk("reset_processing", 32'(bus.processing), 32'h0);
        chk("reset_rs1_val", bus.read_rs1_val, 32'h0);
        rst_n = 1;

        // 1: basic read of two written registers
        wb(5, 32'h1234); tick();
        wb(6, 32'h10);   tick();
        bus.wb_valid = 0;
        decode(5, 6, 0, 1, 1, 0);
        tick();
        bus.decode_valid = 0;
        chk("t1_check_processing", 32'(bus.processing), 32'h1);
        chk("t1_check_not_valid", 32'(bus.read_valid), 32'h0);
        tick();
        chk("t1_valid", 32'(bus.read_valid), 32'h1);
        chk("t1_rs1", bus.read_rs1_val, 32'h1234);
        chk("t1_rs2", bus.read_rs2_val, 32'h10);
        tick();
        chk("t1_idle_valid", 32'(bus.read_valid), 32'h0);
        chk("t1_idle_processing", 32'(bus.processing), 32'h0);

        // 2: x0 writes are dropped and x0 reads as zero
        wb(0, 32'hFFFF); tick();
        bus.wb_valid = 0;
        decode(0, 0, 0, 1, 1, 0);
        tick();
        bus.decode_valid = 0;
        tick();
        chk("t2_valid", 32'(bus.read_valid), 32'h1);
        chk("t2_rs1_zero", bus.read_rs1_val, 32'h0);
        chk("t2_rs2_zero", bus.read_rs2_val, 32'h0);
        tick();
        run_clean(5, 6, 0, 0);

        // 3: RAW hazard on x7 resolved by a late writeback
        run_clean(5, 0, 7, 1);
        decode(7, 0, 0, 1, 0, 0);
        tick();
        bus.decode_valid = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_stall_valid", 32'(bus.read_valid), 32'h0);
            chk("t3_stall_processing", 32'(bus.processing), 32'h1);
        end
        wb(7, 32'hABCD);
        tick();
        bus.wb_valid = 0;
`ifndef REGREAD_BYPASS_EN
        chk("t3_no_bypass_extra_stall", 32'(bus.read_valid), 32'h0);
        tick();
`endif
        chk("t3_valid", 32'(bus.read_valid), 32'h1);
        chk("t3_rs1", bus.read_rs1_val, 32'hABCD);
        tick();

        // 4: execute back-pressure holds the operands
        decode(5, 6, 0, 1, 1, 0);
        bus.execute_processing = 1;
        tick();
        bus.decode_valid = 0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_hold_valid", 32'(bus.read_valid), 32'h1);
            chk("t4_hold_processing", 32'(bus.processing), 32'h1);
            chk("t4_hold_rs1", bus.read_rs1_val, 32'h1234);
            chk("t4_hold_rs2", bus.read_rs2_val, 32'h10);
        end
        bus.execute_processing = 0;
        tick();
        chk("t4_accepted", 32'(bus.read_valid), 32'h0);

        // 5: dispatch to x3 coinciding with a writeback to x3 leaves x3 pending
        decode(0, 0, 3, 0, 0, 1);
        tick();
        bus.decode_valid = 0;
        tick();
        wb(3, 32'h33);
        tick();
        bus.wb_valid = 0;
        decode(3, 0, 0, 1, 0, 0);
        tick();
        bus.decode_valid = 0;
        tick(); tick(); tick();
        chk("t5_still_stalled", 32'(bus.read_valid), 32'h0);
        wb(3, 32'h44);
        tick();
        bus.wb_valid = 0;
`ifndef REGREAD_BYPASS_EN
        tick();
`endif
        chk("t5_valid", 32'(bus.read_valid), 32'h1);
        chk("t5_rs1", bus.read_rs1_val, 32'h44);
        tick();

        // 6: reset while stalled on x9
        run_clean(0, 0, 9, 1);
        decode(9, 0, 0, 1, 0, 0);
        tick();
        bus.decode_valid = 0;
        tick(); tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("t6_reset_valid", 32'(bus.read_valid), 32'h0);
        chk("t6_reset_processing", 32'(bus.processing), 32'h0);
        decode(9, 0, 0, 1, 0, 0);
        tick();
        bus.decode_valid = 0;
        tick();
        chk("t6_no_stall", 32'(bus.read_valid), 32'h1);
        chk("t6_rs1_zero", bus.read_rs1_val, 32'h0);
        tick();

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            rst_n                  = ($urandom_range(0, 499) != 0);
            bus.decode_valid       = ($urandom_range(0, 1) == 1);
            bus.decode_rs1         = 5'($urandom_range(0, 7));
            bus.decode_rs2         = 5'($urandom_range(0, 7));
            bus.decode_rd          = 5'($urandom_range(0, 7));
            bus.decode_uses_rs1    = ($urandom_range(0, 3) != 0);
            bus.decode_uses_rs2    = ($urandom_range(0, 3) != 0);
            bus.decode_writes_rd   = ($urandom_range(0, 1) == 1);
            bus.execute_processing = ($urandom_range(0, 9) < 3);
            bus.wb_valid           = ($urandom_range(0, 9) < 3);
            bus.wb_rd              = 5'($urandom_range(0, 7));
            bus.wb_val             = $urandom;
            tick();
        end
        rst_n = 1;
        quiet();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
